// File: rtl/jpeg_fifo_out_if.sv
// Handshake bundle between the entropy coder and the output packer.
// The master side writes 24-bit chunks; the slave side returns packed words.
interface jpeg_fifo_out_if;
    logic        enable;
    logic [23:0] data_in;
    logic [31:0] JPEG_bitstream;
    logic        data_ready;
    logic [4:0]  orc_reg;

    modport master (
        output enable,
        output data_in,
        input  JPEG_bitstream,
        input  data_ready,
        input  orc_reg
    );

    modport slave (
        input  enable,
        input  data_in,
        output JPEG_bitstream,
        output data_ready,
        output orc_reg
    );
endinterface

// File: rtl/jpeg_fifo_out.sv
// JPEG output packer: 24-bit chunks through a FIFO into 32-bit MSB-first words.
// Define FIFO_OUT_BYTE_STUFF_EN to insert 0x00 after every 0xFF byte.
module jpeg_fifo_out #(
    parameter int FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             rst,
    jpeg_fifo_out_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [23:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [79:0] acc_q, acc_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        rdy_q, rdy_d;

    logic        empty, full, pop, push;
    logic [79:0] acc_e;
    logic [6:0]  cnt_e;
    logic [23:0] head;
    logic [47:0] exp_bits;
    logic [6:0]  exp_len;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef FIFO_OUT_BYTE_STUFF_EN
    always_comb begin
        logic [7:0] b;
        b        = 8'h00;
        exp_bits = '0;
        exp_len  = '0;
        for (int i = 0; i < 3; i++) begin
            b        = head[23-8*i -: 8];
            exp_bits = exp_bits | ({b, 40'b0} >> exp_len);
            // the stuffed 0x00 is the zero fill left below each 0xFF
            exp_len  = exp_len + ((b == 8'hFF) ? 7'd16 : 7'd8);
        end
    end
`else
    assign exp_bits = {head, 24'b0};
    assign exp_len  = 7'd24;
`endif

    always_comb begin
        acc_e  = acc_q;
        cnt_e  = cnt_q;
        word_d = word_q;
        rdy_d  = 1'b0;
        if (cnt_q >= 7'd32) begin
            word_d = acc_q[79:48];
            rdy_d  = 1'b1;
            acc_e  = {acc_q[47:0], 32'b0};
            cnt_e  = cnt_q - 7'd32;
        end

        pop  = !empty && (cnt_e <= 7'd31);
        push = bus.enable && (!full || pop);

        acc_d = acc_e;
        cnt_d = cnt_e;
        if (pop) begin
            acc_d = acc_e | ({exp_bits, 32'b0} >> cnt_e);
            cnt_d = cnt_e + exp_len;
        end

        wr_ptr_d = wr_ptr_q + (push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (pop ? 1'b1 : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.JPEG_bitstream = word_q;
    assign bus.data_ready     = rdy_q;
    assign bus.orc_reg        = cnt_q[4:0];
endmodule

// File: tb/tb_jpeg_fifo_out.sv
// Bench for jpeg_fifo_out: directed steps plus random traffic against
// a bit-queue reference model of the packed stream.
module tb_jpeg_fifo_out;
    logic clk = 1'b0;
    logic rst = 1'b1;

    jpeg_fifo_out_if bus ();

    jpeg_fifo_out #(.FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int first_pulse = 0;
    int base = 0;
    bit bq[$];
    logic [31:0] got[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_push(logic [23:0] d);
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = d[23-8*i -: 8];
            for (int k = 7; k >= 0; k--) bq.push_back(b[k]);
`ifdef FIFO_OUT_BYTE_STUFF_EN
            if (b == 8'hFF)
                for (int k = 0; k < 8; k++) bq.push_back(1'b0);
`endif
        end
    endtask

    task automatic tick();
        logic [31:0] w;
        if (rst) bq.delete();
        else if (bus.enable) model_push(bus.data_in);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.data_ready === 1'b1) begin
            pulses++;
            if (first_pulse == 0) first_pulse = cyc - base;
            got.push_back(bus.JPEG_bitstream);
            chk("word_avail", {31'b0, bq.size() >= 32}, 32'd1);
            if (bq.size() >= 32) begin
                w = '0;
                for (int k = 0; k < 32; k++) w = {w[30:0], bq.pop_front()};
                chk("model_word", bus.JPEG_bitstream, w);
            end
        end
    endtask

    task automatic idle(int n);
        bus.enable = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write1(logic [23:0] d);
        bus.enable  = 1'b1;
        bus.data_in = d;
        tick();
        bus.enable  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        first_pulse = 0;
        got.delete();
    endtask

    initial begin
        bus.enable  = 1'b1;
        bus.data_in = 24'h123456;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_word", bus.JPEG_bitstream, 32'h0);
            chk("rst_rdy", {31'b0, bus.data_ready}, 32'h0);
            chk("rst_orc", {27'b0, bus.orc_reg}, 32'h0);
        end
        rst = 1'b0;
        bus.enable = 1'b0;
        pulses = 0;
        idle(1);

        base = cyc;
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_in = 24'h01E240 + 24'(i);
            tick();
        end
        idle(20);
        chk("stream_pulses", pulses, 7);
        chk("stream_first", first_pulse, 4);
        if (got.size() == 7) begin
            chk("stream_w0", got[0], 32'h01E24001);
            chk("stream_w1", got[1], 32'hE24101E2);
            chk("stream_w2", got[2], 32'h4201E243);
            chk("stream_w6", got[6], 32'h01E24801);
        end
        chk("stream_orc", {27'b0, bus.orc_reg}, 32'd16);
        chk("stream_rdy", {31'b0, bus.data_ready}, 32'h0);

        do_reset();
        write1(24'hABCDEF);
        idle(5);
        chk("part_orc", {27'b0, bus.orc_reg}, 32'd24);
        chk("part_none", pulses, 0);
        write1(24'h123456);
        idle(5);
        chk("part_pulses", pulses, 1);
        if (got.size() == 1) chk("part_word", got[0], 32'hABCDEF12);
        chk("part_orc2", {27'b0, bus.orc_reg}, 32'd16);

        do_reset();
        write1(24'hFFFFFF);
        write1(24'h000000);
        idle(6);
`ifdef FIFO_OUT_BYTE_STUFF_EN
        chk("stuff_pulses", pulses, 2);
        if (got.size() == 2) begin
            chk("stuff_w0", got[0], 32'hFF00FF00);
            chk("stuff_w1", got[1], 32'hFF000000);
        end
        chk("stuff_orc", {27'b0, bus.orc_reg}, 32'd8);
`else
        chk("stuff_pulses", pulses, 1);
        if (got.size() == 1) chk("stuff_w0", got[0], 32'hFFFFFF00);
        chk("stuff_orc", {27'b0, bus.orc_reg}, 32'd16);
`endif

        do_reset();
        for (int i = 0; i < 3; i++) write1(24'h01E240);
        bus.enable = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.enable = 1'b0;
        pulses = 0;
        idle(10);
        chk("mid_pulses", pulses, 0);
        chk("mid_orc", {27'b0, bus.orc_reg}, 32'd0);
        write1(24'hABCDEF);
        idle(3);
        chk("mid_orc2", {27'b0, bus.orc_reg}, 32'd24);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.enable  = $urandom_range(0, 1) == 1;
            bus.data_in = 24'($urandom);
            tick();
        end
        idle(40);
        chk("rand_left", {31'b0, bq.size() < 32}, 32'd1);
        chk("rand_orc", {27'b0, bus.orc_reg}, 32'(bq.size() % 32));
        chk("rand_some", {31'b0, pulses > 50}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jpeg_fifo_out.md
# jpeg_fifo_out

Output packing stage at the tail of the JPEG encoder datapath. Accepts 24-bit entropy-coded chunks (three bytes, MSB byte first) into a small input FIFO. Packs them into a continuous MSB-first bitstream and emits it as 32-bit words with a one-cycle `data_ready` strobe. Reports the count of leftover bits not yet emitted on `orc_reg`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, input FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: write strobe; `data_in` is captured on every edge where it is high.
- `data_in` in 24: bytes [23:16], [15:8], [7:0], emitted in that order.
- `JPEG_bitstream` out 32: last completed word, earliest bit in bit 31; holds between words.
- `data_ready` out 1: high for exactly one cycle per new word on `JPEG_bitstream`.
- `orc_reg` out 5: residual bit count, equal to accumulator count mod 32.

## Operation
- The input FIFO is synchronous, `FIFO_DEPTH` × 24.
  - A write happens when `enable` is high and the FIFO is not full, or is full and a pop occurs on the same edge.
  - A write to a full FIFO with no same-edge pop is dropped silently.
- The bit accumulator is 80 bits wide, MSB-aligned, with count `cnt` (0..79). Each edge applies two steps in order:
  1. Emit: if `cnt` ≥ 32, the top 32 bits go to `JPEG_bitstream`, `data_ready` is set to 1, the accumulator shifts left by 32 and `cnt` −= 32. Otherwise `data_ready` is set to 0.
  2. Pop: if the FIFO is non-empty and the post-emit `cnt` ≤ 31, the head entry is expanded and appended directly below the valid bits, and `cnt` increases by the expanded length (24, or up to 48 with stuffing).
- `orc_reg` takes the resulting `cnt` mod 32 on each edge.
- Only one word is emitted per cycle.
- There is no flush: residual bits stay until enough later data completes a word.
- Throughput: without stuffing, the block sustains one entry per cycle indefinitely and the FIFO never holds more than one entry.

## Timing
- Reset values: `JPEG_bitstream`=0, `data_ready`=0, `orc_reg`=0, FIFO empty, `cnt`=0, accumulator=0.
- `rst` overrides `enable` on the same edge.
- Reset mid-stream discards all buffered data, with no further `data_ready` pulses.
- Latency:
  - An entry written at edge N into an empty FIFO is appended at edge N+1.
  - A word completed by an append at edge M is emitted at edge M+1.
  - `data_ready` is therefore high in the cycle after edge M+1.
- With back-to-back writes starting at edge 1, the first `data_ready` pulse follows edge 4.
- Pop and write on the same edge are both legal at any occupancy.

## Configuration
- `FIFO_OUT_BYTE_STUFF_EN` defined: every 0xFF byte of an entry is followed by an inserted 0x00 byte (JPEG marker escaping). Entry length is 24 + 8·(number of 0xFF bytes) bits. The FIFO may back up and drop writes when full.
- Macro undefined: bytes pass unchanged, and entry length is always 24.

## Test plan
- Reset: hold `rst` 2 cycles with `enable`=1 → all outputs 0 and no `data_ready`.
- Stream: write 0x01E240+i for i=0..9 on consecutive cycles, then idle 20 cycles:
  - exactly 7 `data_ready` pulses;
  - words 0x01E24001, 0xE24101E2, 0x4201E243, …, last 0x01E24801;
  - final `orc_reg`=16 and `data_ready`=0.
- Partial word: write 0xABCDEF → `orc_reg`=24 and no pulse. Then write 0x123456 → one pulse with word 0xABCDEF12 and `orc_reg`=16.
- Stuffing, macro defined: write 0xFFFFFF then 0x000000 → words 0xFF00FF00 and 0xFF000000, `orc_reg`=8.
- Stuffing, macro undefined: same input → word 0xFFFFFF00, `orc_reg`=16.
- Reset mid-stream: after 3 writes of 0x01E240, assert `rst` → `orc_reg`=0 and no further pulses. A subsequent write of 0xABCDEF gives `orc_reg`=24.
